// File: rtl/pulpemu_jtag_master.sv
// JTAG initiator: turns reset/IR/DR/idle commands into TCK/TMS/TDI waveforms and captures TDO.
// Latency: N TCK periods of 2*CLK_DIV cycles each; response valid at handshake + N*2*CLK_DIV + 1.
// Backpressure: one command in flight; the response is held until rsp_ready_i. Optional TRST via PULPEMU_JTAG_TRST_EN.
module pulpemu_jtag_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [5:0]  cmd_len_i,
  input  logic [31:0] cmd_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        tck_o,
  output logic        tms_o,
  output logic        tdi_o,
  input  logic        tdo_i
`ifdef PULPEMU_JTAG_TRST_EN
  ,
  output logic        trst_no
`endif
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_SAMP = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_END  = DW'(2 * CLK_DIV - 1);

  localparam logic [1:0] OP_RST  = 2'd0;
  localparam logic [1:0] OP_IR   = 2'd1;
  localparam logic [1:0] OP_DR   = 2'd2;
  localparam logic [1:0] OP_IDLE = 2'd3;

  // Each state names the TAP state the chip is in during the current TCK period.
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_TLR     = 4'd1;
  localparam logic [3:0] ST_SEL_DR  = 4'd2;
  localparam logic [3:0] ST_SEL_IR  = 4'd3;
  localparam logic [3:0] ST_CAPTURE = 4'd4;
  localparam logic [3:0] ST_SHIFT   = 4'd5;
  localparam logic [3:0] ST_EXIT1   = 4'd6;
  localparam logic [3:0] ST_UPDATE  = 4'd7;
  localparam logic [3:0] ST_RUN     = 4'd8;
  localparam logic [3:0] ST_RSP     = 4'd9;

  logic [3:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [5:0]    len_q, len_d;
  logic [31:0]   data_q, data_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic          tck_q, tck_d;
  logic          tms_q, tms_d;
  logic          tdi_q, tdi_d;
  logic [31:0]   cap_q, cap_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [31:0]   rsp_dat_q, rsp_dat_d;
  logic          trst_d;
  logic          step;
  logic [5:0]    len_clamp;

  // Zero-length commands still do one bit/clock; anything above 32 saturates.
  assign len_clamp = (cmd_len_i == 6'd0) ? 6'd1 :
                     (cmd_len_i > 6'd32) ? 6'd32 : cmd_len_i;

  // Next-state: TCK divider, period-by-period TAP walk, TDO capture and response.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    len_d     = len_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    tck_d     = tck_q;
    tms_d     = tms_q;
    tdi_d     = tdi_q;
    cap_d     = cap_q;
    rsp_vld_d = rsp_vld_q;
    rsp_dat_d = rsp_dat_q;
    trst_d    = 1'b1;
    step      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          len_d   = len_clamp;
          data_d  = cmd_data_i;
          cap_d   = '0;
          cnt_d   = '0;
          div_d   = '0;
          state_d = (cmd_op_i == OP_RST) ? ST_TLR : ST_RUN;
          step    = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_vld_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        div_d = (div_q == DIV_END) ? '0 : div_q + DW'(1);
        if (div_q == DIV_RISE) tck_d = 1'b1;
        if (div_q == DIV_SAMP && state_q == ST_SHIFT) cap_d = {tdo_i, cap_q[31:1]};
        if (div_q == DIV_END) begin
          tck_d = 1'b0;
          step  = 1'b1;
          cnt_d = cnt_q + 6'd1;
          case (state_q)
            ST_TLR:     if (cnt_q == 6'd5) state_d = ST_RSP;
            ST_RUN: begin
              if (op_q == OP_IDLE) begin
                if (cnt_q == len_q - 6'd1) state_d = ST_RSP;
              end else begin
                state_d = ST_SEL_DR;
                cnt_d   = '0;
              end
            end
            ST_SEL_DR:  begin state_d = (op_q == OP_IR) ? ST_SEL_IR : ST_CAPTURE; cnt_d = '0; end
            ST_SEL_IR:  begin state_d = ST_CAPTURE; cnt_d = '0; end
            ST_CAPTURE: begin state_d = ST_SHIFT; cnt_d = '0; end
            ST_SHIFT: begin
              if (cnt_q == len_q - 6'd1) begin
                state_d = ST_EXIT1;
                cnt_d   = '0;
              end
            end
            ST_EXIT1:   begin state_d = ST_UPDATE; cnt_d = '0; end
            default:    state_d = ST_RSP;
          endcase
          if (state_d == ST_RSP) begin
            rsp_vld_d = 1'b1;
            // Capture filled from the top; right-align the len valid bits.
            rsp_dat_d = (op_q == OP_IR || op_q == OP_DR) ? (cap_q >> (6'd32 - len_q)) : '0;
          end
        end
      end
    endcase
    // Pin values for the TCK period that is about to start.
    if (step && state_d != ST_RSP) begin
      tdi_d = 1'b0;
      case (state_d)
        ST_TLR:    begin tms_d = (cnt_d < 6'd5); trst_d = !(cnt_d < 6'd5); end
        ST_RUN:    tms_d = (op_d != OP_IDLE);
        ST_SEL_DR: tms_d = (op_d == OP_IR);
        ST_SHIFT:  begin tms_d = (cnt_d == len_d - 6'd1); tdi_d = data_d[cnt_d[4:0]]; end
        ST_EXIT1:  tms_d = 1'b1;
        default:   tms_d = 1'b0;
      endcase
    end else if (step) begin
      tdi_d = 1'b0;
    end
  end

  // State and pin registers; async reset puts the pads in their safe idle levels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_RST;
      len_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      tck_q     <= 1'b0;
      tms_q     <= 1'b1;
      tdi_q     <= 1'b0;
      cap_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tck_q     <= tck_d;
      tms_q     <= tms_d;
      tdi_q     <= tdi_d;
      cap_q     <= cap_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

`ifdef PULPEMU_JTAG_TRST_EN
  logic trst_q;
  // TRST follows the period boundaries of the reset op; held high otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     trst_q <= 1'b1;
    else if (step) trst_q <= trst_d;
  end
  assign trst_no = trst_q;
`else
  logic unused_trst;
  assign unused_trst = trst_d;
`endif

  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign rsp_valid_o = rsp_vld_q;
  assign rsp_data_o  = rsp_dat_q;
  assign tck_o       = tck_q;
  assign tms_o       = tms_q;
  assign tdi_o       = tdi_q;

endmodule

// File: tb/tb_pulpemu_jtag_master.sv
// Scoreboard bench for pulpemu_jtag_master: random and directed commands against a
// sequence-level JTAG model; a monitor checks each response as the DUT presents it.
module tb_pulpemu_jtag_master;
  localparam int CLK_DIV = 2;
  localparam int PER = 2 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'd0;
  logic [5:0]  cmd_len_i = 6'd0;
  logic [31:0] cmd_data_i = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        tck_o, tms_o, tdi_o;
  logic        tdo_i = 1'b0;
`ifdef PULPEMU_JTAG_TRST_EN
  logic        trst_no;
`endif

  pulpemu_jtag_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_len_i(cmd_len_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i)
`ifdef PULPEMU_JTAG_TRST_EN
    , .trst_no(trst_no)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rsp;
    int          n;
    logic [63:0] tms;
    logic [63:0] tdi;
    logic [63:0] trst;
    int          issue;
  } exp_t;
  exp_t sb[$];

  // Observed pin values at each rising TCK of the current command.
  logic [63:0] obs_tms, obs_tdi;
`ifdef PULPEMU_JTAG_TRST_EN
  logic [63:0] obs_trst;
`endif
  int obs_n = 0;
  // Chip-side TDO source: which TCK periods are shift periods, and the bits to return.
  int cur_pre = 0, cur_len = 0, per_idx = 0;
  logic [31:0] cur_pat = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected TMS/TDI per TCK period and the response, from the op's published sequence.
  function automatic exp_t model(input int op, input int len, input logic [31:0] data,
                                 input logic [31:0] pat);
    exp_t e;
    int l, k, pre;
    l = (len == 0) ? 1 : (len > 32) ? 32 : len;
    e.tms = '0; e.tdi = '0; e.trst = '1; e.rsp = '0; e.issue = 0;
    k = 0;
    if (op == 0) begin
      for (int i = 0; i < 6; i++) begin
        e.tms[k] = (i < 5);
        e.trst[k] = (i >= 5);
        k++;
      end
    end else if (op == 3) begin
      k = l;
    end else begin
      pre = (op == 1) ? 4 : 3;
      for (int i = 0; i < pre; i++) begin
        e.tms[k] = (i == 0) || (op == 1 && i == 1);
        k++;
      end
      for (int i = 0; i < l; i++) begin
        e.tms[k] = (i == l - 1);
        e.tdi[k] = data[i];
        k++;
      end
      e.tms[k] = 1'b1; k++;
      e.tms[k] = 1'b0; k++;
      e.rsp = (l == 32) ? pat : (pat & ((32'h1 << l) - 32'h1));
    end
    e.n = k;
    return e;
  endfunction

  task automatic drive_tdo();
    if (per_idx >= cur_pre && per_idx < cur_pre + cur_len)
      tdo_i = cur_pat[per_idx - cur_pre];
    else
      tdo_i = 1'($urandom_range(0, 1));
  endtask

  // TCK observer and chip TDO driver (TDO changes after each falling TCK).
  initial begin
    logic tck_prev;
    tck_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (tck_o && !tck_prev && obs_n < 64) begin
        obs_tms[obs_n] = tms_o;
        obs_tdi[obs_n] = tdi_o;
`ifdef PULPEMU_JTAG_TRST_EN
        obs_trst[obs_n] = trst_no;
`endif
        obs_n++;
      end
      if (!tck_o && tck_prev) begin
        per_idx++;
        drive_tdo();
      end
      tck_prev = tck_o;
    end
  end

  // Response monitor: pops the scoreboard on each new response.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid_o && !prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %h, no response expected (t=%0t)", rsp_data_o, $time);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", 64'(rsp_data_o), 64'(e.rsp));
          chk("rsp_latency", 64'(cyc - e.issue), 64'(e.n * PER + 1));
          chk("tck_count", 64'(obs_n), 64'(e.n));
          chk("tms_seq", obs_tms, e.tms);
          chk("tdi_seq", obs_tdi, e.tdi);
`ifdef PULPEMU_JTAG_TRST_EN
          chk("trst_seq", obs_trst, e.trst);
`endif
        end
      end
      prev = rsp_valid_o;
    end
  end

  task automatic do_cmd(input int op, input int len, input logic [31:0] data,
                        input logic [31:0] pat, input int bp, input bit expect_rsp);
    exp_t e;
    int t;
    e = model(op, len, data, pat);
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op[1:0];
    cmd_len_i   = len[5:0];
    cmd_data_i  = data;
    cur_pre = (op == 1) ? 4 : (op == 2) ? 3 : 0;
    cur_len = (op == 1 || op == 2) ? e.n - cur_pre - 2 : 0;
    cur_pat = pat;
    per_idx = 0;
    obs_n   = 0;
    obs_tms = '0;
    obs_tdi = '0;
`ifdef PULPEMU_JTAG_TRST_EN
    obs_trst = '1;
`endif
    drive_tdo();
    t = 0;
    while (!cmd_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready_o) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready_o stayed 0, required 1 within 100 cycles");
      cmd_valid_i = 1'b0;
      return;
    end
    e.issue = cyc;
    if (expect_rsp) sb.push_back(e);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    if (!expect_rsp) return;
    t = 0;
    while (!rsp_valid_o && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!rsp_valid_o) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid_o stayed 0, required 1 within 1000 cycles");
      return;
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid_o), 64'd1);
      chk("bp_data", 64'(rsp_data_o), 64'(e.rsp));
      chk("bp_cmd_ready", 64'(cmd_ready_o), 64'd0);
      chk("bp_tck", 64'(tck_o), 64'd0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    chk("ready_after_rsp", 64'(cmd_ready_o), 64'd1);
    chk("valid_after_rsp", 64'(rsp_valid_o), 64'd0);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tck", 64'(tck_o), 64'd0);
    chk("rst_tms", 64'(tms_o), 64'd1);
    chk("rst_tdi", 64'(tdi_o), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
`ifdef PULPEMU_JTAG_TRST_EN
    chk("rst_trst", 64'(trst_no), 64'd1);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready_o), 64'd1);

    // Directed cases
    do_cmd(0, 0, 32'd0, 32'd0, 0, 1'b1);
    do_cmd(1, 5, 32'h1F, 32'h1, 0, 1'b1);
    do_cmd(2, 32, 32'hDEADBEEF, 32'h249511C3, 1, 1'b1);
    do_cmd(2, 0, $urandom, $urandom, 0, 1'b1);
    do_cmd(2, 40, $urandom, $urandom, 0, 1'b1);
    do_cmd(3, 7, $urandom, $urandom, 0, 1'b1);
    do_cmd(1, 32, $urandom, $urandom, 10, 1'b1);

    // Randomized commands
    for (int i = 0; i < 25; i++)
      do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), $urandom, $urandom,
             int'($urandom_range(0, 3)), 1'b1);

    // Reset in the middle of a DR shift: command dropped, no response.
    do_cmd(2, 32, $urandom, $urandom, 0, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tck", 64'(tck_o), 64'd0);
    chk("midrst_tms", 64'(tms_o), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_ready_after", 64'(cmd_ready_o), 64'd1);
    do_cmd(0, 0, 32'd0, 32'd0, 0, 1'b1);
    do_cmd(2, 13, $urandom, $urandom, 2, 1'b1);

    t = 0;
    while (sb.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulpemu_jtag_master.md
# pulpemu_jtag_master

FPGA-side JTAG initiator for the pulpemu emulation top. It drives the chip's JTAG pads (tck/tms/tdi/trst, sampling tdo) from a simple command/response interface so on-board logic can reset the TAP and shift IR/DR. It sits next to the reference clock dividers in the emulation wrapper, on the far end of the chip's TAP responder. It generates the TCK waveform and walks the IEEE 1149.1 state sequences internally.

## Interface
- CLK_DIV, 4: TCK half-period in clk_i cycles; legal ≥1.
- clk_i  in  1  system clock (zynq_clk domain).
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid_i  in  1  command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_op_i  in  2  0 = TAP reset, 1 = shift IR, 2 = shift DR, 3 = idle clocks.
- cmd_len_i  in  6  bit count (shift) or TCK count (idle).
- cmd_data_i  in  32  TDI data, LSB shifted first.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed.
- rsp_data_o  out  32  captured TDO bits, LSB = first captured bit.
- tck_o  out  1  JTAG clock.
- tms_o  out  1  JTAG mode select.
- tdi_o  out  1  JTAG data to chip.
- tdo_i  in  1  JTAG data from chip.
- trst_no  out  1  JTAG reset, active-low; present only with PULPEMU_JTAG_TRST_EN.

## Operation
- States: IDLE, TLR, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE, RUN, RSP.
- IDLE: cmd_ready_o = 1 only here. Handshake latches op, clamped length and data.
- Length clamp: 0 → 1, 33..63 → 32.
- Every TCK period emits one TMS (and TDI) value.
- Reset op: TMS = 1,1,1,1,1,0 (6 TCK). TAP ends in Run-Test/Idle.
- IR op: TMS = 1,1,0,0, then len shift bits, then 1,0. TMS = 1 on the last shift bit (Exit1-IR), then Update, then RTI. Total len+6 TCK.
- DR op: TMS = 1,0,0, then len shift bits (TMS = 1 on last), then 1,0. Total len+5 TCK.
- Idle op: len TCK with TMS = 0.
- TDI = data[i] during shift bit i; TDI = 0 outside SHIFT.
- TDO is sampled on each rising TCK edge within SHIFT into a right-filling register. Result: rsp_data_o[len-1:0] = bits in capture order; upper bits = 0.
- Reset and idle ops return rsp_data_o = 0.
- Every command produces exactly one response.
- RSP: rsp_valid_o held with stable data until rsp_ready_i. Then return to IDLE; cmd_ready_o rises the following cycle.

## Timing
- Reset values: tck_o = 0, tms_o = 1, tdi_o = 0, cmd_ready_o = 0 while rst_i high (1 from the first cycle after release), rsp_valid_o = 0, rsp_data_o = 0, trst_no = 1.
- tck_o idles low.
- TCK period = 2·CLK_DIV clk_i cycles:
  - TMS/TDI update in the first cycle of the low phase.
  - tck_o rises after CLK_DIV cycles; tdo_i is sampled in that same clk_i cycle.
  - tck_o falls after CLK_DIV more.
- Cycle timing from the command handshake in cycle 0:
  - First TMS value is driven in cycle 1.
  - rsp_valid_o rises in cycle N·2·CLK_DIV + 1, where N = TCK count of the op.
- tck_o stays low while in RSP or IDLE.
- rst_i mid-operation: all outputs take reset values immediately (async). The command is dropped and no response is issued. The TAP state is then undefined until a reset op.

## Configuration
- PULPEMU_JTAG_TRST_EN defined:
  - trst_no port exists.
  - Reset op drives trst_no = 0 for the first 5 TCK periods, concurrent with TMS = 1; it returns to 1 for the sixth.
- Undefined: no trst_no port; reset relies on TMS only.

## Test plan
- CLK_DIV = 2, reset op → tms_o high over 5 rising tck_o edges then low for 1; rsp_valid_o at cycle 25; rsp_data_o = 0. With the macro, trst_no is low for 20 cycles.
- IR op, len = 5, data = 0x1F, TAP model capture 0b00001 → TMS sequence 1,1,0,0,0,0,0,0,1,1,0; tdi bits 1,1,1,1,1; rsp_data_o = 0x00000001.
- DR op, len = 32, data = 0xDEADBEEF, model IDCODE 0x249511C3 → tdi LSB-first equals 0xDEADBEEF; rsp_data_o = 0x249511C3; 37 TCK periods.
- Response backpressure: rsp_ready_i low 10 cycles → rsp_valid_o/rsp_data_o stable, cmd_ready_o = 0, tck_o = 0; acceptance → cmd_ready_o = 1 next cycle.
- Length clamp: DR len = 0 → 1 shift bit (6 TCK); len = 40 → 32 shift bits (37 TCK).
- rst_i asserted mid DR shift → tck_o = 0, tms_o = 1, rsp_valid_o = 0 the same cycle; no response after release; a following reset op completes normally.
